iter_div: RTL

- Self-contained, parametrised iterative radix-2 restoring divider.
- Computes quotient and remainder of a W-bit dividend by a W-bit divisor, selectable signed or unsigned per operation.
- Replaces the vendor-IP divider wrapper in the execute stage for DIV/DIVU. Adds a full valid/ready handshake on both sides, pipeline flush, divide-by-zero flagging and a fixed, known latency.

---
 rtl/div_pkg.sv | 22 ++
 rtl/iter_div_if.sv | 29 ++
 rtl/div_step.sv | 22 ++
 rtl/iter_div.sv | 124 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // abs_w works on a fixed 64-bit container; callers zero-extend their
  // W-bit operand and truncate the result back, so W may be at most 64.
  localparam int ABS_MAX_W = 64;

  // Conditional two's complement: returns -v when neg is set, v otherwise.
  // The low W bits of the result are correct for any W <= ABS_MAX_W.
  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] v,
                                                 input logic                 neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/iter_div_if.sv
// Operand/result bus of the iterative divider.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds valid and its payload stable until that
// edge; ready never depends combinationally on valid.
interface iter_div_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on W-bit magnitudes.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] partial_rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;

  // partial_rem < divisor_mag on entry, so the shifted value fits W+1 bits and
  // whichever value is kept afterwards fits back into W bits.
  always_comb begin
    shifted  = {partial_rem, dvd_bit};
    q_bit    = (shifted >= {1'b0, divisor_mag});
    rem_next = q_bit ? W'(shifted - {1'b0, divisor_mag}) : W'(shifted);
  end

endmodule

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider: W CALC cycles, one FIX cycle, then the
// result is held in DONE until the consumer takes it.
module iter_div
  import div_pkg::*;
#(
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  iter_div_if.slave  bus,
  output div_state_e state_dbg
);

  localparam int CNT_W = $clog2(W + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic             dbz_q, dbz_d;
  logic [W-1:0]     dvs_mag_q, dvs_mag_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     prem_q, prem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             dbz_out_q, dbz_out_d;

  logic             accept;
  logic [W-1:0]     step_rem;
  logic             step_q_bit;

  assign accept = bus.in_valid && (state_q == IDLE) && !flush;

  div_step #(.W(W)) u_step (
    .partial_rem (prem_q),
    .dvd_bit     (shreg_q[W-1]),
    .divisor_mag (dvs_mag_q),
    .rem_next    (step_rem),
    .q_bit       (step_q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      dvs_mag_q <= '0;
      shreg_q   <= '0;
      prem_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      dbz_q     <= dbz_d;
      dvs_mag_q <= dvs_mag_d;
      shreg_q   <= shreg_d;
      prem_q    <= prem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    cnt_d     = cnt_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    dbz_d     = dbz_q;
    dvs_mag_d = dvs_mag_q;
    shreg_d   = shreg_q;
    prem_d    = prem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_out_d = dbz_out_q;
    if (accept) begin
      dvd_neg_d = bus.is_signed & bus.dividend[W-1];
      dvs_neg_d = bus.is_signed & bus.divisor[W-1];
      dbz_d     = (bus.divisor == '0);
      shreg_d   = W'(abs_w(ABS_MAX_W'(bus.dividend), dvd_neg_d));
      dvs_mag_d = W'(abs_w(ABS_MAX_W'(bus.divisor), dvs_neg_d));
      prem_d    = '0;
      cnt_d     = CNT_W'(W);
    end else if (!flush && state_q == CALC) begin
      prem_d  = step_rem;
      shreg_d = {shreg_q[W-2:0], step_q_bit};
      cnt_d   = cnt_q - CNT_W'(1);
    end else if (!flush && state_q == FIX) begin
      // A zero divisor leaves r_mag = |dividend|, so re-applying the dividend
      // sign restores the raw dividend; only the quotient needs the bypass.
      quo_d     = dbz_q ? '1 : W'(abs_w(ABS_MAX_W'(shreg_q), dvd_neg_q ^ dvs_neg_q));
      rem_d     = W'(abs_w(ABS_MAX_W'(prem_q), dvd_neg_q));
      dbz_out_d = dbz_q;
    end
  end

  always_comb begin
    bus.in_ready    = (state_q == IDLE);
    bus.out_valid   = (state_q == DONE);
    bus.quotient    = quo_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_out_q;
    state_dbg       = state_q;
  end

endmodule
